raster_cmd_scheduler: RTL and testbench

Arbitrates rasterizer commands from two requesters (host decoder = req0, auxiliary pattern source = req1) into a small command FIFO. Dispatches one command at a time to the 8x8 rasterizer using its single-cycle cmd_ready strobe. Tracks the rasterizer's draw and 64-pixel serialisation phases via frame_sync, so no command is ever issued while the rasterizer is busy. Sits between the command decode logic and the rasterizer instance.

---
 rtl/raster_cmd_scheduler.sv | 154 +++++++++++++++
 tb/tb_raster_cmd_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_cmd_scheduler.sv
// Two-requester arbiter, command FIFO and dispatch FSM for the 8x8 rasterizer.
// Define RASTER_SCHED_PRIO_EN for strict req0 priority instead of round-robin.
`timescale 1ns/1ps
module raster_cmd_scheduler #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DRAIN_CYCLES = 64,
  parameter int unsigned SYNC_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req0_valid,
  input  logic [19:0]                   req0_word,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [19:0]                   req1_word,
  output logic                          req1_ready,
  input  logic                          frame_sync,
  output logic                          cmd_ready,
  output logic [1:0]                    out_cmd,
  output logic [2:0]                    out_x1,
  output logic [2:0]                    out_y1,
  output logic [2:0]                    out_x2,
  output logic [2:0]                    out_y2,
  output logic [2:0]                    out_width,
  output logic [2:0]                    out_height,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_timeout,
  output logic [7:0]                    frames_done
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned TW = $clog2(SYNC_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_SYNC, DRAIN} state_t;

  state_t        state;
  logic [19:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] head, tail;
  logic [LW-1:0] level;
  logic [19:0]   out_word;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic          grant, full, empty, push, pop, drain_end;
  logic [19:0]   push_word;

  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level == '0);

`ifdef RASTER_SCHED_PRIO_EN
  always_comb grant = !req0_valid && req1_valid;
`else
  logic last_grant;

  always_comb begin
    grant = ~last_grant;
    if (req0_valid && !req1_valid)      grant = 1'b0;
    else if (req1_valid && !req0_valid) grant = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_grant <= 1'b1;
    else if (push) last_grant <= grant;
  end
`endif

  assign req0_ready = !full && !grant;
  assign req1_ready = !full && grant;
  assign push       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign push_word  = grant ? req1_word : req0_word;
  assign drain_end  = (state == DRAIN) && (cnt == CW'(DRAIN_CYCLES - 1));
  assign pop        = !empty && ((state == IDLE) || drain_end);

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      out_word    <= '0;
      cnt         <= '0;
      timer       <= '0;
      err_timeout <= 1'b0;
      frames_done <= '0;
    end else begin
      cmd_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state     <= ISSUE;
            cmd_ready <= 1'b1;
            out_word  <= mem[head];
          end
        end
        ISSUE: begin
          state <= WAIT_SYNC;
          timer <= '0;
        end
        WAIT_SYNC: begin
          // Timeout compares against SYNC_TIMEOUT-1 so the abort lands on the same edge the counter would reach SYNC_TIMEOUT.
          if (frame_sync) begin
            state <= DRAIN;
            cnt   <= '0;
          end else if (timer == TW'(SYNC_TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DRAIN: begin
          cnt <= cnt + CW'(1);
          if (drain_end) begin
            frames_done <= frames_done + 8'd1;
            if (pop) begin
              state     <= ISSUE;
              cmd_ready <= 1'b1;
              out_word  <= mem[head];
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign fifo_level = level;
  assign out_cmd    = out_word[19:18];
  assign out_x1     = out_word[17:15];
  assign out_y1     = out_word[14:12];
  assign out_x2     = out_word[11:9];
  assign out_y2     = out_word[8:6];
  assign out_width  = out_word[5:3];
  assign out_height = out_word[2:0];
endmodule

// File: tb/tb_raster_cmd_scheduler.sv
// Randomized and directed bench for raster_cmd_scheduler against a timeline model of the dispatch protocol.
`timescale 1ns/1ps
module tb_raster_cmd_scheduler;
  localparam int DEPTH   = 4;
  localparam int DRAIN   = 64;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, frame_sync = 1'b0;
  logic [19:0] req0_word = '0, req1_word = '0;
  logic        req0_ready, req1_ready, cmd_ready, busy, err_timeout;
  logic [1:0]  out_cmd;
  logic [2:0]  out_x1, out_y1, out_x2, out_y2, out_width, out_height;
  logic [2:0]  fifo_level;
  logic [7:0]  frames_done;
  logic [19:0] dut_word;

  raster_cmd_scheduler #(.FIFO_DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN), .SYNC_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_word(req0_word), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_word(req1_word), .req1_ready(req1_ready),
    .frame_sync(frame_sync), .cmd_ready(cmd_ready),
    .out_cmd(out_cmd), .out_x1(out_x1), .out_y1(out_y1), .out_x2(out_x2), .out_y2(out_y2),
    .out_width(out_width), .out_height(out_height),
    .busy(busy), .fifo_level(fifo_level), .err_timeout(err_timeout), .frames_done(frames_done)
  );

  always #5 clk = ~clk;
  assign dut_word = {out_cmd, out_x1, out_y1, out_x2, out_y2, out_width, out_height};

  int          cyc = 0;
  int unsigned n_checks = 0, n_fail = 0;

  // Requester sources, model FIFO contents and the log of DUT dispatches.
  logic [19:0] q0[$], q1[$], mq[$], disp[$], exp_order[$];
  int          disp_t[$];

  logic        m_last;
  logic [19:0] m_out;
  logic [7:0]  m_frames;
  logic        m_err;
  bit          m_waiting;
  int          m_issue, m_busy_until, m_dec, m_frame_at;
  int          rast_t, rast_skip;
  bit          rast_en = 1'b1, stray_en = 1'b0, rand_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    q0.delete();
    q1.delete();
    m_last       = 1'b1;
    m_out        = '0;
    m_frames     = '0;
    m_err        = 1'b0;
    m_waiting    = 1'b0;
    m_issue      = -1000;
    m_busy_until = -1;
    m_dec        = 0;
    m_frame_at   = -1;
    rast_t       = -100;
    rast_skip    = 0;
  endfunction

  function automatic bit m_grant(input bit v0, input bit v1);
`ifdef RASTER_SCHED_PRIO_EN
    return !v0 && v1;
`else
    if (v0 && v1) return !m_last;
    return v1;
`endif
  endfunction

  function automatic logic [19:0] rand_word();
    logic [19:0] w;
    w = 20'($urandom);
    if ($urandom_range(7) == 0) w[19:12] = 8'b01_111_111;
    return w;
  endfunction

  task automatic tick();
    bit v0, v1, resp, g, full, acc, dec;
    if (rand_mode) begin
      if (q0.size() == 0 && $urandom_range(3) == 0) q0.push_back(rand_word());
      if (q1.size() == 0 && $urandom_range(4) == 0) q1.push_back(rand_word());
    end
    v0 = q0.size() > 0;
    v1 = q1.size() > 0;
    req0_valid = v0;
    req1_valid = v1;
    req0_word  = v0 ? q0[0] : 20'($urandom);
    req1_word  = v1 ? q1[0] : 20'($urandom);
    resp = rast_en && (cyc == rast_t + 2);
    frame_sync = resp || (stray_en && !m_waiting && $urandom_range(7) == 0);
    #1;
    full = (mq.size() == DEPTH);
    g    = m_grant(v0, v1);
    if (v0) check("req0_ready", req0_ready, !full && !g);
    if (v1) check("req1_ready", req1_ready, !full && g);
    check("cmd_ready", cmd_ready, cyc == m_issue);
    check("out_word", dut_word, m_out);
    check("busy", busy, m_waiting || cyc <= m_busy_until || cyc == m_issue);
    check("fifo_level", fifo_level, mq.size());
    check("err_timeout", err_timeout, m_err);
    check("frames_done", frames_done, m_frames);
    if (cmd_ready) begin
      disp.push_back(dut_word);
      disp_t.push_back(cyc);
      if (rast_skip > 0) begin
        rast_skip--;
        rast_t = -100;
      end else begin
        rast_t = cyc;
      end
    end
    @(posedge clk);
    if (rst_n) begin
      if (m_waiting && cyc > m_issue) begin
        if (frame_sync) begin
          m_waiting    = 1'b0;
          m_busy_until = cyc + DRAIN;
          m_dec        = cyc + DRAIN;
          m_frame_at   = cyc + DRAIN;
        end else if (cyc == m_issue + TIMEOUT) begin
          m_waiting    = 1'b0;
          m_err        = 1'b1;
          m_busy_until = cyc;
          m_dec        = cyc + 1;
        end
      end
      if (cyc == m_frame_at) m_frames++;
      dec = !m_waiting && cyc >= m_dec && mq.size() > 0;
      if (dec) begin
        m_out     = mq.pop_front();
        m_issue   = cyc + 1;
        m_waiting = 1'b1;
      end
      acc = ((v0 && !g) || (v1 && g)) && !full;
      if (acc) begin
        if (g) mq.push_back(q1.pop_front());
        else   mq.push_back(q0.pop_front());
        m_last = g;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rand_mode = 1'b0;
    stray_en  = 1'b0;
    model_reset();
    disp.delete();
    disp_t.delete();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int p, nd;
    logic [19:0] a[3], b[3];
    @(negedge clk);

    // Single command from req0: latency, fields, one completed frame.
    do_reset();
    p = cyc;
    q0.push_back({2'b01, 3'd3, 3'd2, 3'd5, 3'd6, 3'd1, 3'd4});
    repeat (80) tick();
    check("a_dispatches", disp.size(), 1);
    if (disp.size() > 0) begin
      check("a_latency", disp_t[0] - p, 2);
      check("a_cmd", disp[0][19:18], 2'b01);
      check("a_x1", disp[0][17:15], 3'd3);
      check("a_y1", disp[0][14:12], 3'd2);
    end
    check("a_frames", frames_done, 1);
    check("a_busy", busy, 0);

    // Both requesters loaded with three words each; order and spacing.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a[i] = {2'b10, 18'($urandom)};
      b[i] = {2'b11, 18'($urandom)};
      q0.push_back(a[i]);
      q1.push_back(b[i]);
    end
    exp_order.delete();
`ifdef RASTER_SCHED_PRIO_EN
    for (int i = 0; i < 3; i++) exp_order.push_back(a[i]);
    for (int i = 0; i < 3; i++) exp_order.push_back(b[i]);
`else
    for (int i = 0; i < 3; i++) begin
      exp_order.push_back(a[i]);
      exp_order.push_back(b[i]);
    end
`endif
    repeat (6 * 67 + 30) tick();
    check("b_dispatches", disp.size(), 6);
    for (int i = 0; i < 6 && i < disp.size(); i++) check("b_order", disp[i], exp_order[i]);
    for (int i = 1; i < disp_t.size(); i++) check("b_spacing", disp_t[i] - disp_t[i-1], 67);

    // Rasterizer ignores the first dispatch: timeout, then recovery.
    do_reset();
    rast_skip = 1;
    q0.push_back(rand_word());
    q0.push_back(rand_word());
    repeat (100) tick();
    check("c_err", err_timeout, 1);
    check("c_dispatches", disp.size(), 2);
    check("c_frames", frames_done, 1);

    // Asynchronous reset in the middle of DRAIN with two commands queued.
    do_reset();
    for (int i = 0; i < 3; i++) q0.push_back(rand_word());
    repeat (20) tick();
    check("d_level_before", fifo_level, 2);
    check("d_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("d_rst_cmd_ready", cmd_ready, 0);
    check("d_rst_level", fifo_level, 0);
    check("d_rst_busy", busy, 0);
    check("d_rst_out", dut_word, 0);
    check("d_rst_frames", frames_done, 0);
    model_reset();
    nd = disp.size();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (150) tick();
    check("d_no_dispatch", disp.size(), nd);

    // Random traffic with stray frame_sync pulses and occasional timeouts.
    do_reset();
    rand_mode = 1'b1;
    stray_en  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rast_skip = ($urandom_range(2) == 0) ? 1 : 0;
      repeat (500) tick();
    end
    rand_mode = 1'b0;
    repeat (700) tick();

    // 256 NO_OPs wrap the frame counter back to zero.
    do_reset();
    stray_en = 1'b1;
    for (int i = 0; i < 256; i++) q1.push_back({2'b00, 18'($urandom)});
    repeat (256 * 67 + 100) tick();
    check("f_dispatches", disp.size(), 256);
    check("f_frames_wrap", frames_done, 0);
    check("f_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
